// File: rtl/and_vector_checker_pkg.sv
// rtl/and_vector_checker_pkg.sv - shared types, constants and golden functions for the AND-tree checker
//
// Contents:
//   state_e        sweep sequencer states
//   BIT_A..BIT_D   position of each netlist input within the 4-bit vector
//   NUM_VECTORS    number of vectors in one exhaustive sweep
//   exp_z/exp_ab   golden responses of the AND-tree netlist for a vector
package and_vector_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int unsigned BIT_A       = 3;
  localparam int unsigned BIT_B       = 2;
  localparam int unsigned BIT_C       = 1;
  localparam int unsigned BIT_D       = 0;
  localparam int unsigned NUM_VECTORS = 16;

  function automatic logic exp_z(input logic [3:0] vec);
    return vec[BIT_C] & vec[BIT_D];
  endfunction

  function automatic logic exp_ab(input logic [3:0] vec);
    return vec[BIT_A] & vec[BIT_B];
  endfunction

endpackage

// File: rtl/and_vector_checker_settle_timer.sv
// rtl/and_vector_checker_settle_timer.sv - 4-bit loadable down-counter timing the settle window
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i into the counter this cycle
//   load_val_i  value to load (settle length in cycles)
//   expired_o   counter is at its last settle cycle (value 1 or below)
module settle_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       expired_o
);

  logic [3:0] cnt_q, cnt_d;

  // Counts down every cycle it is not being loaded and parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The SETTLE state sees values SETTLE..1, so value 1 marks its final cycle.
  assign expired_o = (cnt_q <= 4'd1);

endmodule

// File: rtl/and_vector_checker.sv
// rtl/and_vector_checker.sv - exhaustive stimulus/response checker for the AND-tree test netlist
//
// Parameter SETTLE (0..15): cycles between applying a vector and sampling it.
// Optional macro AND_VECTOR_CHECKER_FAIL_LOG_EN: builds the first-failing-vector log.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   START           request one sweep (honoured only while idle)
//   A, B, C, D      stimulus to the netlist, VEC[3:0] = {A,B,C,D}
//   Z_IN, AB_AND_IN netlist responses
//   BUSY            sweep in progress
//   DONE            one-cycle pulse at sweep completion
//   PASS            last completed sweep had no failing vector
//   ERR_COUNT       failing vectors in the last completed sweep
//   FIRST_FAIL      first failing vector of the last completed sweep (0 when not built)
module and_vector_checker
  import and_vector_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       Z_IN,
  input  logic       AB_AND_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_COUNT,
  output logic [3:0] FIRST_FAIL
);

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       tmr_load;
  logic       tmr_expired;
  logic       vec_fail;

  settle_timer u_settle_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tmr_load),
    .load_val_i (4'(SETTLE)),
    .expired_o  (tmr_expired)
  );

  // A vector that misses on both outputs still counts as a single failure.
  assign vec_fail = (Z_IN != exp_z(vec_q)) || (AB_AND_IN != exp_ab(vec_q));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    DONE     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          cnt_d   = 5'd0;
          vec_d   = 4'd0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_expired) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (vec_fail) begin
          cnt_d = cnt_q + 5'd1;
        end
        if (vec_q == 4'(NUM_VECTORS - 1)) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        DONE    = 1'b1;
        err_d   = cnt_q;
        pass_d  = (cnt_q == 5'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 5'd0;
      err_q   <= 5'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus is the vector register itself, so it changes exactly when DRIVE is entered.
  assign A         = vec_q[BIT_A];
  assign B         = vec_q[BIT_B];
  assign C         = vec_q[BIT_C];
  assign D         = vec_q[BIT_D];
  assign BUSY      = (state_q != S_IDLE);
  assign PASS      = pass_q;
  assign ERR_COUNT = err_q;

`ifdef AND_VECTOR_CHECKER_FAIL_LOG_EN
  logic [3:0] ff_run_q, ff_run_d;
  logic [3:0] ff_pub_q, ff_pub_d;

  // A zero running count at a failing sample means this is the sweep's first failure.
  always_comb begin
    ff_run_d = ff_run_q;
    ff_pub_d = ff_pub_q;
    if (state_q == S_IDLE && START) begin
      ff_run_d = 4'd0;
    end
    if (state_q == S_SAMPLE && vec_fail && cnt_q == 5'd0) begin
      ff_run_d = vec_q;
    end
    if (state_q == S_DONE) begin
      ff_pub_d = ff_run_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ff_run_q <= 4'd0;
      ff_pub_q <= 4'd0;
    end else begin
      ff_run_q <= ff_run_d;
      ff_pub_q <= ff_pub_d;
    end
  end

  assign FIRST_FAIL = ff_pub_q;
`else
  assign FIRST_FAIL = 4'd0;
`endif

endmodule

// File: tb/tb_and_vector_checker.sv
// tb/tb_and_vector_checker.sv - self-checking bench for and_vector_checker (SETTLE=2 and SETTLE=0 instances)
module tb_and_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2];
  int         mode [2];
  logic       a [2], b [2], c [2], d [2];
  logic       z [2], ab [2];
  logic       busy [2], done [2], pass [2];
  logic [4:0] errc [2];
  logic [3:0] ff [2];
  bit         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_vector_checker #(.SETTLE(2)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start[0]),
    .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]),
    .Z_IN(z[0]), .AB_AND_IN(ab[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_COUNT(errc[0]), .FIRST_FAIL(ff[0])
  );

  and_vector_checker #(.SETTLE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]),
    .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]),
    .Z_IN(z[1]), .AB_AND_IN(ab[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_COUNT(errc[1]), .FIRST_FAIL(ff[1])
  );

  // Netlist stand-ins: mode 0 good, 1 Z stuck at 0, 2 AB_AND inverted.
  for (genvar g = 0; g < 2; g++) begin : g_net
    assign z[g]  = (mode[g] == 1) ? 1'b0 : (c[g] & d[g]);
    assign ab[g] = (mode[g] == 2) ? ~(a[g] & b[g]) : (a[g] & b[g]);
  end

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int i);
    checks++;
    failures++;
    $display("FAIL %s[%0d]: timed out waiting for DONE", name, i);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int sweep_len(input int i);
    return 16 * (settle_of(i) + 2) + 1;
  endfunction

  // Exhaustively grades a faulted netlist against the golden AND functions.
  task automatic sweep_result(input int md, output logic [4:0] e, output logic [3:0] f);
    int va, vb, vc, vd, nz, nab;
    e = 5'd0;
    f = 4'd0;
    for (int v = 0; v < 16; v++) begin
      va = (v >> 3) & 1; vb = (v >> 2) & 1; vc = (v >> 1) & 1; vd = v & 1;
      nz  = (md == 1) ? 0 : (vc & vd);
      nab = (md == 2) ? (1 - (va & vb)) : (va & vb);
      if (nz != (vc & vd) || nab != (va & vb)) begin
        if (e == 5'd0) f = 4'(v);
        e = e + 5'd1;
      end
    end
`ifndef AND_VECTOR_CHECKER_FAIL_LOG_EN
    f = 4'd0;
`endif
  endtask

  bit         m_act [2];
  int         m_t [2];
  logic [3:0] m_hold [2];
  logic [4:0] m_err [2];
  logic       m_pass [2];
  logic [3:0] m_ff [2];

  // m_t counts cycles since the edge that accepted START; sweep ends at cycle sweep_len.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_hold[i] = 4'd0;
        m_err[i] = 5'd0; m_pass[i] = 1'b0; m_ff[i] = 4'd0;
      end else if (m_act[i]) begin
        if (m_t[i] == sweep_len(i)) begin
          m_act[i]  = 1'b0;
          m_hold[i] = 4'd15;
          sweep_result(mode[i], m_err[i], m_ff[i]);
          m_pass[i] = (m_err[i] == 5'd0);
        end else begin
          m_t[i]++;
        end
      end else if (start[i]) begin
        m_act[i] = 1'b1;
        m_t[i]   = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] ev;
        if (!m_act[i])                 ev = m_hold[i];
        else if (m_t[i] == sweep_len(i)) ev = 4'd15;
        else                           ev = 4'((m_t[i] - 1) / (settle_of(i) + 2));
        check("busy", i, 32'(busy[i]), 32'(m_act[i]));
        check("done", i, 32'(done[i]), 32'(m_act[i] && m_t[i] == sweep_len(i)));
        check("vector", i, 32'({a[i], b[i], c[i], d[i]}), 32'(ev));
        check("err_count", i, 32'(errc[i]), 32'(m_err[i]));
        check("pass", i, 32'(pass[i]), 32'(m_pass[i]));
        check("first_fail", i, 32'(ff[i]), 32'(m_ff[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_sweep(input int i, input int md, output int done_cyc);
    int n;
    mode[i] = md;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    n = 0;
    done_cyc = -1;
    while (n < 200 && done_cyc < 0) begin
      @(negedge clk);
      n++;
      if (done[i] === 1'b1) done_cyc = n;
    end
    if (done_cyc < 0) timeout("sweep", i);
    @(negedge clk);
  endtask

  initial begin
    int dc, n, ndone, n1, n2;
    logic [3:0] exp_ff_stuck;
`ifdef AND_VECTOR_CHECKER_FAIL_LOG_EN
    exp_ff_stuck = 4'b0011;
`else
    exp_ff_stuck = 4'b0000;
`endif
    mode[0] = 0; mode[1] = 0;
    start[0] = 1'b0; start[1] = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 0, 32'(busy[0]), 0);
    check("rst_vec", 0, 32'({a[0], b[0], c[0], d[0]}), 0);
    check("rst_pass", 0, 32'(pass[0]), 0);
    check("rst_err", 0, 32'(errc[0]), 0);

    // Clean netlist, SETTLE=2
    run_sweep(0, 0, dc);
    check("good_done_cycle", 0, 32'(dc), 65);
    check("good_err", 0, 32'(errc[0]), 0);
    check("good_pass", 0, 32'(pass[0]), 1);
    check("good_ff", 0, 32'(ff[0]), 0);
    check("good_hold_vec", 0, 32'({a[0], b[0], c[0], d[0]}), 15);

    // Z stuck at 0: vectors 3, 7, 11, 15 fail
    run_sweep(0, 1, dc);
    check("stuckz_err", 0, 32'(errc[0]), 4);
    check("stuckz_pass", 0, 32'(pass[0]), 0);
    check("stuckz_ff", 0, 32'(ff[0]), 32'(exp_ff_stuck));

    // AB_AND inverted: every vector fails
    run_sweep(0, 2, dc);
    check("abinv_err", 0, 32'(errc[0]), 16);
    check("abinv_pass", 0, 32'(pass[0]), 0);
    check("abinv_ff", 0, 32'(ff[0]), 0);

    // SETTLE=0 with a START pulse mid-sweep that must be ignored
    mode[1] = 0;
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    n = 0; ndone = 0; dc = -1;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (n == 10) start[1] = 1'b1;
      if (n == 11) start[1] = 1'b0;
      if (done[1] === 1'b1) begin
        ndone++;
        if (dc < 0) dc = n;
      end
    end
    check("s0_done_cycle", 1, 32'(dc), 33);
    check("s0_done_count", 1, 32'(ndone), 1);
    check("s0_pass", 1, 32'(pass[1]), 1);

    // START held high: back-to-back sweeps separated by one idle cycle
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk);
    n = 0; n1 = -1; n2 = -1;
    while (n < 200 && n2 < 0) begin
      @(negedge clk);
      n++;
      if (done[1] === 1'b1) begin
        if (n1 < 0) n1 = n; else n2 = n;
      end
    end
    start[1] = 1'b0;
    if (n2 < 0) timeout("b2b", 1);
    else check("b2b_gap", 1, 32'(n2 - n1), 34);
    check("b2b_first", 1, 32'(n1), 33);
    repeat (3) @(negedge clk);

    // Reset during a stuck-Z sweep, then a clean sweep
    mode[0] = 1;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 0, 32'(busy[0]), 0);
    check("arst_vec", 0, 32'({a[0], b[0], c[0], d[0]}), 0);
    check("arst_err", 0, 32'(errc[0]), 0);
    check("arst_done", 0, 32'(done[0]), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_sweep(0, 0, dc);
    check("post_rst_done_cycle", 0, 32'(dc), 65);
    check("post_rst_err", 0, 32'(errc[0]), 0);
    check("post_rst_pass", 0, 32'(pass[0]), 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
